// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
// Imported by rr_arbiter4_if, rr_pick and rr_arbiter4.
package rr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Bit width needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// gnt_idx exists only when RR_ARB_IDX_OUT_EN is defined.
interface rr_arbiter4_if
  import rr_arb_pkg::*;
#(
  parameter int N = 4
) ();

  localparam int IW = clog2_min1(N);

  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic          gnt_valid;
`ifdef RR_ARB_IDX_OUT_EN
  logic [IW-1:0] gnt_idx;

  modport master (output req, input gnt, input gnt_valid, input gnt_idx);
  modport slave  (input req, output gnt, output gnt_valid, output gnt_idx);
`else
  modport master (output req, input gnt, input gnt_valid);
  modport slave  (input req, output gnt, output gnt_valid);
`endif

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate masked requests so the scan start
// sits at bit 0, take the lowest set bit, then rotate the index back.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int  N  = 4,
  localparam int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          any
);

  // One spare bit so start+offset never overflows before the modulo-N fold.
  localparam int SW = IW + 1;

  logic [N-1:0]  eff;
  logic [N-1:0]  rot;
  logic [IW-1:0] ffo;
  logic [SW-1:0] back_sum;

  assign eff = req & ~mask;

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_rot
    logic [SW-1:0] sum;
    logic [IW-1:0] src;
    assign sum     = {1'b0, start} + SW'(gi);
    assign src     = (sum >= SW'(N)) ? IW'(sum - SW'(N)) : sum[IW-1:0];
    assign rot[gi] = eff[src];
  end

  always_comb begin
    ffo = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        ffo = IW'(i);
        any = 1'b1;
      end
    end
  end

  assign back_sum = {1'b0, start} + {1'b0, ffo};
  assign idx      = (back_sum >= SW'(N)) ? IW'(back_sum - SW'(N)) : back_sum[IW-1:0];

  for (gi = 0; gi < N; gi++) begin : g_onehot
    assign pick[gi] = any && (idx == IW'(gi));
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Lock-style round-robin arbiter with registered one-hot grant and optional
// hold-time preemption. RR_ARB_IDX_OUT_EN adds the registered gnt_idx output.
module rr_arbiter4
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter4_if.slave  bus
);

  localparam int IW = clog2_min1(N);
  localparam int HW = clog2_min1(MAX_HOLD + 1);
  localparam logic [IW-1:0] LAST_RST = IW'(N - 1);
  // With unlimited hold the counter simply parks at its top value.
  localparam logic [HW-1:0] HOLD_SAT = (MAX_HOLD > 0) ? HW'(MAX_HOLD) : {HW{1'b1}};

  arb_state_e    state_reg;
  logic [N-1:0]  gnt_reg;
  logic          gnt_valid_reg;
  logic [IW-1:0] last_reg;
  logic [HW-1:0] hold_cnt_reg;
`ifdef RR_ARB_IDX_OUT_EN
  logic [IW-1:0] gnt_idx_reg;
`endif

  logic [IW-1:0] start;
  logic [N-1:0]  mask;
  logic [N-1:0]  pick;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          owner_drop;
  logic          preempt;

  assign start      = (last_reg == LAST_RST) ? '0 : last_reg + IW'(1);
  // Masking the owner lets one picker serve both release and preemption.
  assign mask       = (state_reg == BUSY) ? gnt_reg : '0;
  assign owner_drop = (state_reg == BUSY) && ((bus.req & gnt_reg) == '0);
  assign preempt    = (MAX_HOLD > 0) && (state_reg == BUSY) && !owner_drop
                      && (hold_cnt_reg == HOLD_SAT);

  rr_pick #(
    .N (N)
  ) u_pick (
    .req   (bus.req),
    .mask  (mask),
    .start (start),
    .pick  (pick),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      gnt_reg       <= '0;
      gnt_valid_reg <= 1'b0;
      last_reg      <= LAST_RST;
      hold_cnt_reg  <= '0;
`ifdef RR_ARB_IDX_OUT_EN
      gnt_idx_reg   <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            state_reg     <= BUSY;
            gnt_reg       <= pick;
            gnt_valid_reg <= 1'b1;
            last_reg      <= pick_idx;
            hold_cnt_reg  <= HW'(1);
`ifdef RR_ARB_IDX_OUT_EN
            gnt_idx_reg   <= pick_idx;
`endif
          end
        end
        BUSY: begin
          if (owner_drop || preempt) begin
            if (pick_any) begin
              // Direct hand-over: no zero or multi-hot cycle in between.
              gnt_reg      <= pick;
              last_reg     <= pick_idx;
              hold_cnt_reg <= HW'(1);
`ifdef RR_ARB_IDX_OUT_EN
              gnt_idx_reg  <= pick_idx;
`endif
            end else if (owner_drop) begin
              state_reg     <= IDLE;
              gnt_reg       <= '0;
              gnt_valid_reg <= 1'b0;
              hold_cnt_reg  <= '0;
            end else begin
              hold_cnt_reg <= HW'(1);
            end
          end else if (hold_cnt_reg != HOLD_SAT) begin
            hold_cnt_reg <= hold_cnt_reg + HW'(1);
          end
        end
        default: begin
          state_reg     <= IDLE;
          gnt_reg       <= '0;
          gnt_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.gnt_valid = gnt_valid_reg;
`ifdef RR_ARB_IDX_OUT_EN
  assign bus.gnt_idx   = gnt_idx_reg;
`endif

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: one instance without preemption, one with MAX_HOLD=3,
// both checked against a requester-level round-robin model.
module tb_rr_arbiter4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_arbiter4_if #(.N(4)) if0 ();
  rr_arbiter4_if #(.N(4)) if3 ();

  rr_arbiter4 #(.N(4), .MAX_HOLD(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  rr_arbiter4 #(.N(4), .MAX_HOLD(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  int err_cnt = 0;
  int chk_cnt = 0;

  // Model state per instance: owner (-1 = nobody), last winner, cycles held.
  int m_owner[2];
  int m_last[2];
  int m_held[2];
  int m_idx[2];
  int mh[2] = '{0, 3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int scan(input int last, input int excl, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (c != excl && r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_last[d]  = 3;
      m_held[d]  = 0;
      m_idx[d]   = 0;
    end
  endtask

  task automatic model_grant(input int d, input int w);
    m_owner[d] = w;
    m_last[d]  = w;
    m_held[d]  = 1;
    m_idx[d]   = w;
  endtask

  task automatic model_step(input logic [3:0] r);
    for (int d = 0; d < 2; d++) begin
      int w;
      if (m_owner[d] < 0) begin
        w = scan(m_last[d], -1, r);
        if (w >= 0) model_grant(d, w);
      end else if (!r[m_owner[d]] || (mh[d] > 0 && m_held[d] == mh[d])) begin
        w = scan(m_last[d], m_owner[d], r);
        if (w >= 0)                 model_grant(d, w);
        else if (!r[m_owner[d]])    m_owner[d] = -1;
        else                        m_held[d] = 1;
      end else begin
        m_held[d]++;
      end
    end
  endtask

  function automatic logic [3:0] exp_gnt(input int d);
    return (m_owner[d] < 0) ? 4'b0000 : (4'b0001 << m_owner[d]);
  endfunction

  // Drives req, lets one edge pass, compares both instances 1 time unit later.
  task automatic cycle(input logic [3:0] r);
    if0.req = r;
    if3.req = r;
    @(posedge clk);
    model_step(r);
    #1;
    chk("gnt_mh0", {28'd0, if0.gnt}, {28'd0, exp_gnt(0)});
    chk("gnt_mh3", {28'd0, if3.gnt}, {28'd0, exp_gnt(1)});
`ifdef RR_ARB_IDX_OUT_EN
    chk("idx_mh0", {30'd0, if0.gnt_idx}, m_idx[0]);
    chk("idx_mh3", {30'd0, if3.gnt_idx}, m_idx[1]);
`endif
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    if0.req = 4'b0000;
    if3.req = 4'b0000;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_gnt_mh0", {28'd0, if0.gnt}, 0);
    chk("rst_gnt_mh3", {28'd0, if3.gnt}, 0);
    #1;
    rst_n = 1'b1;
  endtask

  // Continuous invariants: one-hot-or-zero, valid flag, req-less grant length.
  int rl0 = 0;
  int rl3 = 0;
  logic [3:0] pg0 = '0;
  logic [3:0] pg3 = '0;

  function automatic int rl_upd(input int rl, input logic [3:0] g, input logic [3:0] pg,
                                input logic [3:0] r);
    int reqless;
    reqless = (g != 4'b0000 && (g & r) == 4'b0000) ? 1 : 0;
    return (g != pg) ? reqless : (reqless != 0 ? rl + 1 : 0);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("onehot_mh0", {31'd0, $onehot0(if0.gnt)}, 1);
      chk("onehot_mh3", {31'd0, $onehot0(if3.gnt)}, 1);
      chk("valid_mh0", {31'd0, if0.gnt_valid}, {31'd0, |if0.gnt});
      chk("valid_mh3", {31'd0, if3.gnt_valid}, {31'd0, |if3.gnt});
      chk("reqless_mh0", {31'd0, rl_upd(rl0, if0.gnt, pg0, if0.req) <= 1}, 1);
      chk("reqless_mh3", {31'd0, rl_upd(rl3, if3.gnt, pg3, if3.req) <= 1}, 1);
      rl0 <= rl_upd(rl0, if0.gnt, pg0, if0.req);
      rl3 <= rl_upd(rl3, if3.gnt, pg3, if3.req);
    end
    pg0 <= if0.gnt;
    pg3 <= if3.gnt;
  end

  logic [3:0] t2_order[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] t4_exp[9]   = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010,
                              4'b0010, 4'b0001, 4'b0001, 4'b0001};

  initial begin
    logic [3:0] r;
    logic [3:0] seen[5];
    logic [3:0] last_g;
    int n_seen;

    // 1: reset holds gnt low even with all requests up.
    rst_n   = 1'b0;
    if0.req = 4'b1111;
    if3.req = 4'b1111;
    model_reset();
    @(posedge clk);
    #1;
    chk("t1_rst_gnt", {28'd0, if0.gnt}, 0);
    chk("t1_rst_valid", {31'd0, if0.gnt_valid}, 0);
`ifdef RR_ARB_IDX_OUT_EN
    chk("t1_rst_idx", {30'd0, if0.gnt_idx}, 0);
`endif
    #1;
    rst_n = 1'b1;
    cycle(4'b1111);
    chk("t1_first", {28'd0, if0.gnt}, 32'h1);

    // 2: fairness, each owner drops req after two granted cycles.
    do_reset();
    n_seen = 0;
    last_g = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      r = 4'b1111;
      if (m_owner[0] >= 0 && m_held[0] == 2) r[m_owner[0]] = 1'b0;
      cycle(r);
      chk("t2_nogap", {31'd0, if0.gnt_valid}, 1);
      if (if0.gnt != last_g && n_seen < 5) begin
        seen[n_seen] = if0.gnt;
        n_seen++;
      end
      last_g = if0.gnt;
    end
    for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), {28'd0, seen[i]}, {28'd0, t2_order[i]});

    // 3: pointer wrap from last=3.
    do_reset();
    cycle(4'b1000);
    cycle(4'b0000);
    cycle(4'b0101);
    chk("t3_wrap", {28'd0, if0.gnt}, 32'h1);
    cycle(4'b0100);
    chk("t3_switch", {28'd0, if0.gnt}, 32'h4);

    // 4: preemption after three cycles.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(4'b0011);
      chk($sformatf("t4_preempt%0d", i), {28'd0, if3.gnt}, {28'd0, t4_exp[i]});
    end

    // 5: lone requester keeps the grant through preemption points.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(4'b0100);
      chk("t5_solo", {28'd0, if3.gnt}, 32'h4);
    end

    // 6: asynchronous reset between edges.
    do_reset();
    cycle(4'b1000);
    chk("t6_pre", {28'd0, if0.gnt}, 32'h8);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_mh0", {28'd0, if0.gnt}, 0);
    chk("t6_async_mh3", {28'd0, if3.gnt}, 0);
    chk("t6_async_valid", {31'd0, if0.gnt_valid}, 0);
    model_reset();
    #3;
    rst_n = 1'b1;
    cycle(4'b1000);
    chk("t6_after", {28'd0, if0.gnt}, 32'h8);
`ifdef RR_ARB_IDX_OUT_EN
    chk("t6_idx", {30'd0, if0.gnt_idx}, 3);
`endif

    // Random lock-style traffic: each request bit toggles with probability 1/4.
    do_reset();
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        do_reset();
        r = 4'b0000;
      end
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      end
      cycle(r);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
